// File: rtl/ssd_scan_decoder.sv
// Scan-side decoder for a multiplexed 7-segment display.
// Recovers per-digit hex values and full frames from an/seg.
module ssd_scan_decoder #(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CYCLES = 4,
  parameter logic [NUM_DIGITS-1:0] ENABLE_MASK = 8'h3F
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic                    frame_done,
  output logic                    error,
  output logic [2:0]              err_index
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0] an_s1, an_s2, an_p;
  logic [6:0] seg_s1, seg_s2, seg_p;
  logic [CW-1:0] cnt, cnt_nxt;
  logic captured, differ, capture;

  logic [NUM_DIGITS-1:0] seen, inv, newbit;
  logic [IW-1:0] idx;
  logic blank, single, legal, complete;
  logic [3:0] val;
  logic [4*NUM_DIGITS-1:0] digits_upd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_s1 <= '0;
      an_s2 <= '0;
      an_p <= '0;
      seg_s1 <= '0;
      seg_s2 <= '0;
      seg_p <= '0;
      cnt <= '0;
      captured <= 1'b0;
    end else begin
      an_s1 <= an;
      an_s2 <= an_s1;
      an_p <= an_s2;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      seg_p <= seg_s2;
      cnt <= cnt_nxt;
      if (differ)
        captured <= 1'b0;
      else if (capture)
        captured <= 1'b1;
    end
  end

  // Capture lands on the edge where the counter reaches its top value.
  always_comb begin
    differ = {an_s2, seg_s2} != {an_p, seg_p};
    cnt_nxt = '0;
    if (!differ)
      cnt_nxt = (cnt == CMAX) ? cnt : cnt + CW'(1);
    capture = !differ && (cnt_nxt == CMAX) && !captured;
  end

  always_comb begin
    legal = 1'b1;
    val = 4'h0;
    case (seg_s2)
      7'b0000001: val = 4'h0;
      7'b1001111: val = 4'h1;
      7'b0010010: val = 4'h2;
      7'b0000110: val = 4'h3;
      7'b1001100: val = 4'h4;
      7'b0100100: val = 4'h5;
      7'b0100000: val = 4'h6;
      7'b0001111: val = 4'h7;
      7'b0000000: val = 4'h8;
      7'b0000100: val = 4'h9;
      7'b0001000: val = 4'hA;
      7'b1100000: val = 4'hB;
      7'b0110001: val = 4'hC;
      7'b1000010: val = 4'hD;
      7'b0110000: val = 4'hE;
      7'b0111000: val = 4'hF;
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    inv = ~an_s2;
    blank = (inv == '0);
    single = !blank && ((inv & (inv - NUM_DIGITS'(1))) == '0);
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (inv[i]) idx = IW'(i);
    newbit = NUM_DIGITS'(1) << idx;
    digits_upd = digits;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (IW'(i) == idx) digits_upd[4*i +: 4] = val;
    complete = |(newbit & ENABLE_MASK) &&
      (((seen | newbit) & ENABLE_MASK) == ENABLE_MASK);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits <= '0;
      digit_valid <= '0;
      frame_digits <= '0;
      frame_done <= 1'b0;
      error <= 1'b0;
      err_index <= 3'd0;
      seen <= '0;
    end else begin
      frame_done <= 1'b0;
      error <= 1'b0;
      if (capture && !blank) begin
        if (!single) begin
          error <= 1'b1;
          err_index <= 3'd7;
        end else if (!legal) begin
          error <= 1'b1;
          err_index <= 3'(idx);
          digit_valid[idx] <= 1'b0;
          seen <= '0;
        end else begin
          digits <= digits_upd;
          digit_valid[idx] <= 1'b1;
          if (complete) begin
            frame_done <= 1'b1;
            frame_digits <= digits_upd;
            seen <= '0;
          end else begin
            seen <= seen | (newbit & ENABLE_MASK);
          end
        end
      end
    end
  end

endmodule
